instr_prefetch_master: RTL and testbench

//  Initiator side of the single-outstanding mem bus (mem_valid/mem_ready/mem_wstrb/mem_addr/mem_wdata/mem_rdata).

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/instr_prefetch_master_if.sv | 43 ++++
 rtl/prefetch_fifo.sv | 76 +++++++
 rtl/instr_prefetch_master.sv | 200 ++++++++++++++++++++
 tb/tb_instr_prefetch_master.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg
//   Shared types and constants for the instruction prefetch master and its
//   FIFO: the fetch FSM state encoding, the FIFO entry layout and the bus
//   word size.
// ----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int WORD_BYTES = 4;
    localparam int MEM_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        ERR
    } fetch_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_master_if.sv
// ----------------------------------------------------------------------------
// instr_prefetch_master_if
//   Single-outstanding memory bus between the prefetch master and the
//   instruction memory responder.
//   mem_valid  master->slave  request valid, held until mem_ready
//   mem_ready  slave->master  completion strobe, mem_rdata valid this cycle
//   mem_wstrb  master->slave  byte write strobes
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  write data
//   mem_rdata  slave->master  read data
// ----------------------------------------------------------------------------
interface instr_prefetch_master_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) ();

    logic              mem_valid;
    logic              mem_ready;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_valid,
        output mem_wstrb,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_wstrb,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/prefetch_fifo.sv
// ----------------------------------------------------------------------------
// prefetch_fifo
//   Synchronous FIFO of fetched {addr, data} entries.
//   clk, resetn   clock, synchronous active-low reset
//   push          write push_entry (ignored when full or flushing)
//   push_entry    entry to write
//   pop           drop head (ignored when empty or flushing)
//   flush         empty the FIFO; wins over push and pop
//   head          entry at the read pointer
//   full, empty   occupancy flags
//   count         number of stored entries
// ----------------------------------------------------------------------------
module prefetch_fifo
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Storage carries data only; it is never reset.
    fetch_entry_t entry_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == PTR_W'(DEPTH));
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign head    = entry_mem[rd_ptr_q[IDX_W-1:0]];

    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entry_mem[wr_ptr_q[IDX_W-1:0]] <= push_entry;
    end

endmodule

// File: rtl/instr_prefetch_master.sv
// ----------------------------------------------------------------------------
// instr_prefetch_master
//   Fetches sequential instruction words over a single-outstanding memory
//   bus into a small FIFO and presents them to the core as a valid/ready
//   stream. Supports PC redirect (with flush) and a fetch timeout.
//   clk, resetn      clock, synchronous active-low reset
//   mem              memory bus, master side
//   redirect_valid   single-cycle pulse: load redirect_addr and flush
//   redirect_addr    new PC, low two bits ignored
//   instr_valid      FIFO head valid
//   instr_ready      core accepts head
//   instr_data       head instruction word
//   instr_addr       head instruction address
//   fetch_err        sticky timeout flag, cleared by redirect or reset
// ----------------------------------------------------------------------------
module instr_prefetch_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    instr_prefetch_master_if.master mem,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_addr,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [31:0]             instr_data,
    output logic [ADDR_W-1:0]       instr_addr,
    output logic                    fetch_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(WORD_BYTES - 1);

    fetch_state_t      state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              fetch_err_q, fetch_err_d;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    logic              handshake;
    logic              stalled;
    logic              timeout_hit;
    logic              room_after_push;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] next_pc;

    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wstrb = 4'b0000;
    assign mem.mem_wdata = 32'd0;

    assign instr_valid = ~fifo_empty;
    assign instr_data  = head_entry.data;
    assign instr_addr  = head_entry.addr;
    assign fetch_err   = fetch_err_q;

    // A redirect flushes the FIFO, so a pop in that cycle must not count.
    assign pop         = instr_valid & instr_ready & ~redirect_valid;
    assign handshake   = mem_valid_q & mem.mem_ready;
    assign stalled     = mem_valid_q & ~mem.mem_ready;
    // Fires on the TIMEOUT-th stalled cycle, so mem_valid is high exactly
    // TIMEOUT cycles before it is withdrawn.
    assign timeout_hit = stalled & (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    assign redirect_pc = redirect_addr & ALIGN;
    assign next_pc     = fetch_pc_q + STEP;

    // A push only happens with count < DEPTH (no request is issued while
    // full), so after the push there is room unless count was DEPTH-1 and
    // nothing leaves this cycle.
    assign room_after_push = pop | (fifo_count != CNT_W'(DEPTH - 1));

    assign push_entry = '{addr: fetch_pc_q, data: mem.mem_rdata};

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        fetch_pc_d  = fetch_pc_q;
        tmo_cnt_d   = stalled ? tmo_cnt_q + TMO_W'(1) : tmo_cnt_q;
        fetch_err_d = fetch_err_q;
        push        = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d  = redirect_pc;
            fetch_err_d = 1'b0;
            if (stalled && !timeout_hit) begin
                // Live request must complete; its data is thrown away.
                state_d = DRAIN;
            end else if (handshake) begin
                state_d     = REQ;
                mem_valid_d = 1'b1;
                mem_addr_d  = redirect_pc;
                tmo_cnt_d   = '0;
            end else begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
                tmo_cnt_d   = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_full) begin
                        state_d     = REQ;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = fetch_pc_q;
                        tmo_cnt_d   = '0;
                    end
                end
                REQ: begin
                    if (handshake) begin
                        push       = 1'b1;
                        fetch_pc_d = next_pc;
                        tmo_cnt_d  = '0;
                        if (room_after_push) begin
                            mem_addr_d = next_pc;
                        end else begin
                            state_d     = IDLE;
                            mem_valid_d = 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_d     = ERR;
                        mem_valid_d = 1'b0;
                        fetch_err_d = 1'b1;
                        tmo_cnt_d   = '0;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        // FIFO was flushed at the redirect and nothing was
                        // pushed since, so the new request always has room.
                        state_d    = REQ;
                        mem_addr_d = fetch_pc_q;
                        tmo_cnt_d  = '0;
                    end else if (timeout_hit) begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        tmo_cnt_d   = '0;
                    end
                end
                ERR: begin
                    mem_valid_d = 1'b0;
                end
                default: begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= ADDR_W'(RESET_PC);
            fetch_pc_q  <= ADDR_W'(RESET_PC);
            tmo_cnt_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            tmo_cnt_q   <= tmo_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_instr_prefetch_master.sv
// ----------------------------------------------------------------------------
// tb_instr_prefetch_master
//   Pairs the prefetch master with a 1-cycle-latency memory responder
//   (mem[i] = 0x100 + i). The expected instruction stream after reset or a
//   redirect is the run of sequential word addresses from the start PC,
//   wrapping at 512 bytes; it is queued when the stimulus is issued and
//   popped by an independent monitor on every accepted instruction.
// ----------------------------------------------------------------------------
module tb_instr_prefetch_master;

    localparam int ADDR_W  = 9;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int SPAN    = 512;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [31:0]       instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              fetch_err;

    instr_prefetch_master_if #(.ADDR_W(ADDR_W)) mem_if ();

    instr_prefetch_master #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem            (mem_if),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_addr     (instr_addr),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t exp_q[$];

    task automatic load_expected(input logic [ADDR_W-1:0] start);
        int pc;
        exp_t e;
        exp_q.delete();
        pc = int'(start) & ~3;
        for (int i = 0; i < 512; i++) begin
            e.addr = ADDR_W'(pc);
            e.data = 32'h100 + 32'(pc / 4);
            exp_q.push_back(e);
            pc = (pc + 4) % SPAN;
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem_model [128];
    bit resp_en   = 1'b1;
    bit resp_rand = 1'b0;

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = 32'h100 + 32'(i);
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (mem_if.mem_ready) begin
                mem_if.mem_ready = 1'b0;
                mem_if.mem_rdata = 32'hDEAD_BEEF;
            end else if (mem_if.mem_valid && resp_en &&
                         (!resp_rand || $urandom_range(0, 3) != 0)) begin
                mem_if.mem_ready = 1'b1;
                mem_if.mem_rdata = mem_model[mem_if.mem_addr[8:2]];
            end
        end
    end

    // ---------------- instruction stream monitor ----------------
    int                acc_cnt = 0;
    logic [ADDR_W-1:0] last_acc_addr = '0;
    logic [31:0]       last_acc_data = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && instr_valid && instr_ready && !redirect_valid) begin
                acc_cnt++;
                last_acc_addr = instr_addr;
                last_acc_data = instr_data;
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_addr", 32'(instr_addr), 32'(e.addr));
                    check("instr_data", instr_data, e.data);
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    int                hs_cnt = 0;
    int                valid_cycles = 0;
    int                stall_len = 0;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [ADDR_W-1:0] hs_addrs[$];

    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                check("mem_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
                check("mem_wdata", mem_if.mem_wdata, 32'd0);
                if (prev_valid && !prev_ready) begin
                    if (mem_if.mem_valid)
                        check("mem_addr_stable", 32'(mem_if.mem_addr), 32'(prev_addr));
                    else
                        check("timeout_len", 32'(stall_len), 32'(TIMEOUT));
                end
                if (mem_if.mem_valid) valid_cycles++;
                if (mem_if.mem_valid && mem_if.mem_ready) begin
                    hs_cnt++;
                    if (!redirect_valid) hs_addrs.push_back(mem_if.mem_addr);
                    stall_len = 0;
                end else if (mem_if.mem_valid) begin
                    stall_len++;
                end else begin
                    stall_len = 0;
                end
                prev_valid = mem_if.mem_valid;
                prev_ready = mem_if.mem_ready;
                prev_addr  = mem_if.mem_addr;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_redirect(input logic [ADDR_W-1:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        load_expected(a);
        hs_addrs.delete();
        cycles(1);
        redirect_valid = 1'b0;
        check("instr_valid_after_redirect", 32'(instr_valid), 32'd0);
        check("fetch_err_after_redirect", 32'(fetch_err), 32'd0);
    endtask

    task automatic wait_bus_quiet(input string name);
        int quiet = 0;
        for (int t = 0; t < 200 && quiet < 3; t++) begin
            cycles(1);
            quiet = mem_if.mem_valid ? 0 : quiet + 1;
        end
        check(name, (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_accepts(input string name, input int n);
        int base = acc_cnt;
        for (int t = 0; t < 200 && acc_cnt < base + n; t++) cycles(1);
        check(name, (acc_cnt >= base + n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int found;
        int base;
        int v0;
        int h0;

        cycles(4);
        check("rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
        check("rst_mem_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);

        // 1: sequential fetch from reset
        load_expected('0);
        instr_ready = 1'b1;
        resetn = 1'b1;
        wait_accepts("t1_three_words", 3);

        // 2: FIFO fills to exactly DEPTH requests, one pop frees one slot
        instr_ready = 1'b0;
        wait_bus_quiet("t2_fill_before");
        do_redirect('0);
        cycles(30);
        check("t2_req_count", 32'(hs_addrs.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (hs_addrs.size() > i) check("t2_req_addr", 32'(hs_addrs[i]), 32'(i * 4));
        check("t2_idle_valid", 32'(mem_if.mem_valid), 32'd0);
        instr_ready = 1'b1;
        cycles(1);
        instr_ready = 1'b0;
        cycles(20);
        check("t2_req_count_after_pop", 32'(hs_addrs.size()), 32'd5);
        if (hs_addrs.size() > 4) check("t2_req_after_pop", 32'(hs_addrs[4]), 32'h10);
        check("t2_idle_valid_after_pop", 32'(mem_if.mem_valid), 32'd0);

        // 3: redirect while a request is live
        instr_ready = 1'b1;
        found = 0;
        for (int t = 0; t < 50 && !found; t++) begin
            if (mem_if.mem_valid && !mem_if.mem_ready) found = 1;
            else cycles(1);
        end
        check("t3_live_request", 32'(found), 32'd1);
        do_redirect(9'h041);
        wait_accepts("t3_first_word", 1);
        check("t3_first_addr", 32'(last_acc_addr), 32'h40);
        check("t3_first_data", last_acc_data, 32'h110);

        // 4: timeout sets a sticky error; redirect recovers
        resp_en = 1'b0;
        do_redirect(9'h080);
        for (int t = 0; t < 400 && !fetch_err; t++) cycles(1);
        check("t4_fetch_err", 32'(fetch_err), 32'd1);
        check("t4_valid_low", 32'(mem_if.mem_valid), 32'd0);
        v0 = valid_cycles;
        h0 = hs_cnt;
        cycles(100);
        check("t4_no_requests", 32'(valid_cycles - v0), 32'd0);
        check("t4_no_handshakes", 32'(hs_cnt - h0), 32'd0);
        check("t4_err_sticky", 32'(fetch_err), 32'd1);
        resp_en = 1'b1;
        do_redirect('0);
        wait_accepts("t4_resume", 3);

        // 5: redirect, mem_ready and pop all in the same cycle
        instr_ready = 1'b0;
        cycles(6);
        instr_ready = 1'b1;
        found = 0;
        for (int t = 0; t < 100 && !found; t++) begin
            if (mem_if.mem_ready && instr_valid) found = 1;
            else cycles(1);
        end
        check("t5_aligned_event", 32'(found), 32'd1);
        do_redirect(9'h020);
        wait_accepts("t5_first_word", 1);
        check("t5_first_addr", 32'(last_acc_addr), 32'h20);
        check("t5_first_data", last_acc_data, 32'h108);
        wait_accepts("t5_more_words", 3);

        // 6: address wrap
        instr_ready = 1'b0;
        wait_bus_quiet("t6_fill_before");
        do_redirect(9'h1F8);
        instr_ready = 1'b1;
        for (int t = 0; t < 50 && hs_addrs.size() < 4; t++) cycles(1);
        check("t6_req_count", (hs_addrs.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (hs_addrs.size() >= 4) begin
            check("t6_addr0", 32'(hs_addrs[0]), 32'h1F8);
            check("t6_addr1", 32'(hs_addrs[1]), 32'h1FC);
            check("t6_addr2", 32'(hs_addrs[2]), 32'h000);
            check("t6_addr3", 32'(hs_addrs[3]), 32'h004);
        end
        wait_accepts("t6_words", 4);

        // random traffic: core back-pressure, responder stalls, redirects
        resp_rand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0)
                do_redirect(ADDR_W'($urandom_range(0, SPAN - 1)));
            else
                cycles(1);
        end
        base = acc_cnt;
        instr_ready = 1'b1;
        resp_rand = 1'b0;
        cycles(20);
        check("rand_still_flowing", (acc_cnt > base) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
